console_samp: RTL and testbench

Per-frame channel-scan sequencer sitting directly downstream of the sample-rate tick generator. Each `fs` tick starts one frame: the block requests a conversion for every channel in turn from the ADC interface and streams each result out through a valid/ready port. After the last channel it returns a one-cycle `fd` to the tick generator so that the generator re-arms for the next sample period.

---
 rtl/console_samp.sv | 181 ++++++++++++++++++
 tb/tb_console_samp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_samp.sv
// console_samp: per-frame channel-scan sequencer.
// Each fs tick starts one frame. The block requests a conversion for every
// channel in turn, streams each result out over a valid/ready port, and
// returns a one-cycle fd to the tick generator after the last channel.
// Optional feature macro: CONSOLE_SAMP_TIMEOUT_EN. When it is defined, a
// conversion that goes 256 cycles without adc_ack is replaced by a marker
// sample, and the sticky adc_err port is added.
module console_samp #(
    parameter int NUM_CH = 8,   // channels per frame, 1..16
    parameter int DW     = 16   // sample width
) (
    input  logic          clk,
    input  logic          rst,       // asynchronous, active-low
    input  logic          fs,
    output logic          fd,
    output logic          adc_req,
    output logic [3:0]    adc_ch,
    input  logic          adc_ack,
    input  logic [DW-1:0] adc_data,
    output logic [DW-1:0] dout,
    output logic [3:0]    dout_ch,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic [15:0]   frame_cnt,
`ifdef CONSOLE_SAMP_TIMEOUT_EN
    output logic          adc_err,
`endif
    output logic          overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REQ,
        OUT,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

    state_t        state_q, state_d;
    logic [3:0]    ch_q, ch_d;
    logic          armed_q, armed_d;
    logic          fs_prev_q, fs_prev_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [3:0]    dout_ch_q, dout_ch_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          overrun_q, overrun_d;
    logic          fs_rise;

`ifdef CONSOLE_SAMP_TIMEOUT_EN
    // Sample substituted when the ADC never answers: MSB set, rest zero.
    localparam logic [DW-1:0] TMO_DATA = {1'b1, {(DW-1){1'b0}}};

    logic [8:0] tmo_cnt_q, tmo_cnt_d;
    logic       adc_err_q, adc_err_d;
`endif

    assign fs_rise = fs & ~fs_prev_q;

    // Next-state, datapath and sticky-flag logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d     = state_q;
        ch_d        = ch_q;
        armed_d     = armed_q;
        fs_prev_d   = fs;
        dout_d      = dout_q;
        dout_ch_d   = dout_ch_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
`ifdef CONSOLE_SAMP_TIMEOUT_EN
        adc_err_d   = adc_err_q;
        // Counts cycles spent in REQ; zero everywhere else, so it is zero on entry.
        tmo_cnt_d   = (state_q == REQ) ? tmo_cnt_q + 9'd1 : '0;
`endif

        // Any cycle with fs low re-arms; a level held across fd cannot retrigger.
        if (!fs) begin
            armed_d = 1'b1;
        end

        // A new fs edge while a frame is running is an error; the frame still finishes.
        if (fs_rise && (state_q == REQ || state_q == OUT || state_q == DONE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: state_d = WAIT;

            WAIT: begin
                if (fs && armed_q) begin
                    state_d = REQ;
                    ch_d    = '0;
                    armed_d = 1'b0;
                end
            end

            REQ: begin
                if (adc_ack) begin
                    dout_d    = adc_data;
                    dout_ch_d = ch_q;
                    state_d   = OUT;
                end
`ifdef CONSOLE_SAMP_TIMEOUT_EN
                else if (tmo_cnt_q == 9'd255) begin
                    dout_d    = TMO_DATA;
                    dout_ch_d = ch_q;
                    adc_err_d = 1'b1;
                    state_d   = OUT;
                end
`endif
            end

            OUT: begin
                if (dout_rdy) begin
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + 4'd1;
                        state_d = REQ;
                    end
                end
            end

            DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = WAIT;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            armed_q     <= 1'b1;
            fs_prev_q   <= 1'b0;
            dout_q      <= '0;
            dout_ch_q   <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
`ifdef CONSOLE_SAMP_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            adc_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            ch_q        <= ch_d;
            armed_q     <= armed_d;
            fs_prev_q   <= fs_prev_d;
            dout_q      <= dout_d;
            dout_ch_q   <= dout_ch_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
`ifdef CONSOLE_SAMP_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            adc_err_q   <= adc_err_d;
`endif
        end
    end

    // Moore outputs decoded from the state register.
    assign fd        = (state_q == DONE);
    assign adc_req   = (state_q == REQ);
    assign dout_vld  = (state_q == OUT);
    assign adc_ch    = ch_q;
    assign dout      = dout_q;
    assign dout_ch   = dout_ch_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
`ifdef CONSOLE_SAMP_TIMEOUT_EN
    assign adc_err   = adc_err_q;
`endif

endmodule

// File: tb/tb_console_samp.sv
// Testbench for console_samp: a cycle table for reset and first-frame timing,
// directed frames for backpressure, held fs, overrun and mid-frame reset,
// then randomized frames checked against a frame-level model.
module tb_console_samp;

    localparam int NUM_CH = 8;
    localparam int DW     = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fs = 1'b0;
    logic          adc_ack = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          dout_rdy = 1'b0;
    logic          fd, adc_req, dout_vld, overrun;
    logic [3:0]    adc_ch, dout_ch;
    logic [DW-1:0] dout;
    logic [15:0]   frame_cnt;
`ifdef CONSOLE_SAMP_TIMEOUT_EN
    logic          adc_err;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_frames = 0;
    logic exp_ovr = 1'b0;
    logic exp_err = 1'b0;

    // 50 MHz clock
    always #10 clk = ~clk;

    console_samp #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .fs        (fs),
        .fd        (fd),
        .adc_req   (adc_req),
        .adc_ch    (adc_ch),
        .adc_ack   (adc_ack),
        .adc_data  (adc_data),
        .dout      (dout),
        .dout_ch   (dout_ch),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .frame_cnt (frame_cnt),
`ifdef CONSOLE_SAMP_TIMEOUT_EN
        .adc_err   (adc_err),
`endif
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_fd"},        fd, 0);
        check({tag, "_adc_req"},   adc_req, 0);
        check({tag, "_adc_ch"},    adc_ch, 0);
        check({tag, "_dout"},      dout, 0);
        check({tag, "_dout_ch"},   dout_ch, 0);
        check({tag, "_dout_vld"},  dout_vld, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_overrun"},   overrun, 0);
`ifdef CONSOLE_SAMP_TIMEOUT_EN
        check({tag, "_adc_err"},   adc_err, 0);
`endif
    endtask

    // Frame-level model: channels go 0..NUM_CH-1 in order, each output
    // carries exactly the data the bench returned for that channel, adc_req
    // follows fs/ready by one cycle, and fd closes the frame.
    // Precondition: DUT in WAIT and armed. Returns in the fd cycle.
    task automatic serve_frame(input bit rnd, input int bp_ch, input int bp_len,
                               input int ovr_ch, input int tmo_ch);
        logic [DW-1:0] d;
        int n;
        fs = 1'b1;
        tick();
        for (int c = 0; c < NUM_CH; c++) begin
            check("req_on", adc_req, 1);
            check("req_ch", adc_ch, c);
            check("vld_in_req", dout_vld, 0);
            if (c == tmo_ch) n = 255;
            else             n = rnd ? int'($urandom_range(0, 4)) : 3;
            for (int w = 0; w < n; w++) begin
                adc_ack  = 1'b0;
                adc_data = DW'($urandom);
                dout_rdy = rnd ? 1'($urandom) : 1'b0;
                if (c == ovr_ch) begin
                    fs = (w != 0);
                    if (w == 1) exp_ovr = 1'b1;
                end
                tick();
                check("req_hold", adc_req, 1);
            end
            if (c == tmo_ch) begin
                d = {1'b1, {(DW-1){1'b0}}};
                exp_err = 1'b1;
                adc_ack = 1'b0;
                tick();
            end else begin
                d = rnd ? DW'($urandom) : DW'(c * 'h111);
                adc_ack  = 1'b1;
                adc_data = d;
                dout_rdy = rnd ? 1'($urandom) : 1'b0;
                tick();
            end
            adc_ack  = 1'b0;
            adc_data = DW'($urandom);
            check("vld_on", dout_vld, 1);
            check("dout", dout, d);
            check("dout_ch", dout_ch, c);
            check("req_off", adc_req, 0);
`ifdef CONSOLE_SAMP_TIMEOUT_EN
            check("adc_err", adc_err, exp_err);
`endif
            n = (c == bp_ch) ? bp_len : (rnd ? int'($urandom_range(0, 3)) : 0);
            for (int w = 0; w < n; w++) begin
                dout_rdy = 1'b0;
                adc_ack  = rnd ? 1'($urandom) : 1'b0;
                tick();
                check("bp_vld", dout_vld, 1);
                check("bp_dout", dout, d);
                check("bp_req", adc_req, 0);
            end
            adc_ack  = 1'b0;
            dout_rdy = 1'b1;
            tick();
            dout_rdy = 1'b0;
        end
        check("fd_on", fd, 1);
        check("vld_off_done", dout_vld, 0);
        check("overrun", overrun, exp_ovr);
        exp_frames++;
    endtask

    // Keep fs high for `hold` cycles after fd, then drop it for one cycle.
    task automatic finish_frame(input int hold);
        for (int i = 0; i < hold; i++) begin
            fs = 1'b1;
            tick();
            check("held_fs_req", adc_req, 0);
            check("fd_one", fd, 0);
        end
        fs = 1'b0;
        tick();
        check("post_fd", fd, 0);
        check("post_req", adc_req, 0);
        check("frame_cnt", frame_cnt, 16'(exp_frames));
    endtask

    typedef struct {
        logic          rst_n;
        logic          fs;
        logic          ack;
        logic [DW-1:0] data;
        logic          rdy;
        logic          e_req;
        logic [3:0]    e_ch;
        logic          e_vld;
        logic [DW-1:0] e_dout;
        logic [3:0]    e_dch;
        logic          e_fd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // rst  fs    ack   data        rdy  | req   ch    vld   dout        dch   fd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 4'd0, 1'b1, 16'h1234, 4'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 16'h1234, 4'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 4'd1, 1'b0, 16'h1234, 4'd0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h0111, 1'b1, 1'b0, 4'd1, 1'b1, 16'h0111, 4'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd2, 1'b0, 16'h0111, 4'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 4'd0, 1'b0};

        rst = 1'b0;
        repeat (3) tick();
        check_reset_vals("por");
        rst = 1'b1;

        // Cycle table: first two channels, then a reset during REQ on channel 2.
        for (int i = 0; i < 12; i++) begin
            rst      = vecs[i].rst_n;
            fs       = vecs[i].fs;
            adc_ack  = vecs[i].ack;
            adc_data = vecs[i].data;
            dout_rdy = vecs[i].rdy;
            tick();
            check($sformatf("tv%0d_fd", i),   fd, vecs[i].e_fd);
            check($sformatf("tv%0d_req", i),  adc_req, vecs[i].e_req);
            if (vecs[i].e_req || !vecs[i].rst_n)
                check($sformatf("tv%0d_ch", i), adc_ch, vecs[i].e_ch);
            check($sformatf("tv%0d_vld", i),  dout_vld, vecs[i].e_vld);
            check($sformatf("tv%0d_dout", i), dout, vecs[i].e_dout);
            check($sformatf("tv%0d_dch", i),  dout_ch, vecs[i].e_dch);
        end
        adc_ack  = 1'b0;
        dout_rdy = 1'b0;

        // Abort the frame the table left open.
        rst = 1'b0;
        tick();
        check_reset_vals("abort");
        rst = 1'b1;
        fs  = 1'b0;
        tick();

        // Basic frame with 5 cycles of backpressure on channel 3, then fs held 4 cycles.
        serve_frame(1'b0, 3, 5, -1, -1);
        finish_frame(4);
        // fs re-armed for one cycle: second frame.
        serve_frame(1'b0, -1, 0, -1, -1);
        finish_frame(0);
        // fs pulsed low then high during channel 5.
        serve_frame(1'b0, -1, 0, 5, -1);
        finish_frame(0);

        // Randomized frames; overrun must stay set throughout.
        for (int f = 0; f < 20; f++) begin
            serve_frame(1'b1, -1, 0, -1, -1);
            finish_frame(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) begin
                fs = 1'b0;
                tick();
                check("gap_req", adc_req, 0);
            end
        end

        // Only reset clears overrun and the frame counter.
        rst = 1'b0;
        tick();
        check_reset_vals("clr");
        exp_ovr    = 1'b0;
        exp_frames = 0;
        rst = 1'b1;
        fs  = 1'b0;
        tick();

`ifdef CONSOLE_SAMP_TIMEOUT_EN
        // No ack on channel 1: marker sample after 256 cycles, frame completes.
        serve_frame(1'b0, -1, 0, -1, 1);
        finish_frame(0);
        check("adc_err_sticky", adc_err, 1);
`else
        serve_frame(1'b0, -1, 0, -1, -1);
        finish_frame(0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
